tsi_serial_adapter: RTL

Width adapter between the 32-bit simulation TSI endpoint and a narrow SERIAL_W-bit serial link into the chip under test. Host-to-target TSI words are split into SERIAL_W-bit beats, LSB first, and sent out on the serial link. Target-to-host serial beats are collected into 32-bit words and presented back to the TSI endpoint. It sits directly downstream of the TSI driver's `tsi_in_*` stream and directly upstream of its `tsi_out_*` stream.

---
 rtl/tsi_serial_adapter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tsi_serial_adapter.sv
// Purpose: 32-bit TSI word <-> SERIAL_W-bit serial beat width adapter, LSB beat first.
// Latency: TX beat 0 valid one cycle after word accept; RX word valid one cycle after last beat.
// Backpressure: valid/ready on all four streams, unbounded stalls lose nothing. Stats via TSI_ADAPTER_STATS_EN.
module tsi_serial_adapter #(
  parameter int SERIAL_W = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                host_in_valid,
  output logic                host_in_ready,
  input  logic [31:0]         host_in_bits,
  output logic                ser_out_valid,
  input  logic                ser_out_ready,
  output logic [SERIAL_W-1:0] ser_out_bits,
  input  logic                ser_in_valid,
  output logic                ser_in_ready,
  input  logic [SERIAL_W-1:0] ser_in_bits,
  output logic                host_out_valid,
  input  logic                host_out_ready,
  output logic [31:0]         host_out_bits
`ifdef TSI_ADAPTER_STATS_EN
  ,
  output logic [31:0]         tx_words,
  output logic [31:0]         rx_words
`endif
);

  localparam int BEATS = 32 / SERIAL_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (!(SERIAL_W == 1 || SERIAL_W == 2 || SERIAL_W == 4 ||
        SERIAL_W == 8 || SERIAL_W == 16 || SERIAL_W == 32)) begin : g_bad_serial_w
    $error("tsi_serial_adapter: SERIAL_W must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

  // ---------------- TX path ----------------
  tx_state_t     tx_state, tx_next;
  logic [31:0]   tx_shift;
  logic [BW-1:0] tx_beat;
  logic          host_in_ready_d, ser_out_valid_d;

  logic host_in_fire, ser_out_fire, tx_last;
  assign host_in_fire = host_in_valid && host_in_ready;
  assign ser_out_fire = ser_out_valid && ser_out_ready;
  assign tx_last      = ser_out_fire && (tx_beat == LAST_BEAT);
  // The outgoing beat is always the low slice of the shift register.
  assign ser_out_bits = tx_shift[SERIAL_W-1:0];

  // TX next state: accept a word when idle, return to idle after the last beat fires.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (host_in_fire) tx_next = TX_SEND;
      TX_SEND: if (tx_last)      tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX output decode from the upcoming state so the handshake outputs are registered.
  always_comb begin
    host_in_ready_d = (tx_next == TX_IDLE);
    ser_out_valid_d = (tx_next == TX_SEND);
  end

  // TX state and handshake registers; ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state      <= TX_IDLE;
      host_in_ready <= 1'b0;
      ser_out_valid <= 1'b0;
    end else begin
      tx_state      <= tx_next;
      host_in_ready <= host_in_ready_d;
      ser_out_valid <= ser_out_valid_d;
    end
  end

  // TX datapath: load the word on accept, shift one beat out per serial fire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift <= '0;
      tx_beat  <= '0;
    end else if (host_in_fire) begin
      tx_shift <= host_in_bits;
      tx_beat  <= '0;
    end else if (ser_out_fire) begin
      tx_shift <= tx_shift >> SERIAL_W;
      tx_beat  <= tx_last ? '0 : tx_beat + BW'(1);
    end
  end

  // ---------------- RX path ----------------
  rx_state_t     rx_state, rx_next;
  logic [31:0]   rx_word;
  logic [BW-1:0] rx_beat;
  logic          ser_in_ready_d, host_out_valid_d;

  logic ser_in_fire, host_out_fire, rx_last;
  assign ser_in_fire   = ser_in_valid && ser_in_ready;
  assign host_out_fire = host_out_valid && host_out_ready;
  assign rx_last       = ser_in_fire && (rx_beat == LAST_BEAT);
  assign host_out_bits = rx_word;

  // RX next state: collect BEATS beats, then hold the word until the host takes it.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_COLLECT: if (rx_last)       rx_next = RX_HOLD;
      RX_HOLD:    if (host_out_fire) rx_next = RX_COLLECT;
      default:    rx_next = RX_COLLECT;
    endcase
  end

  // RX output decode from the upcoming state.
  always_comb begin
    ser_in_ready_d   = (rx_next == RX_COLLECT);
    host_out_valid_d = (rx_next == RX_HOLD);
  end

  // RX state and handshake registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state       <= RX_COLLECT;
      ser_in_ready   <= 1'b0;
      host_out_valid <= 1'b0;
    end else begin
      rx_state       <= rx_next;
      ser_in_ready   <= ser_in_ready_d;
      host_out_valid <= host_out_valid_d;
    end
  end

  // RX datapath: drop each beat into its slice; the beat index wraps after the last one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_word <= '0;
      rx_beat <= '0;
    end else if (ser_in_fire) begin
      rx_word[int'(rx_beat) * SERIAL_W +: SERIAL_W] <= ser_in_bits;
      rx_beat <= rx_last ? '0 : rx_beat + BW'(1);
    end
  end

`ifdef TSI_ADAPTER_STATS_EN
  // Word counters: TX counts on the final beat, RX on delivery to the host; both wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_words <= '0;
      rx_words <= '0;
    end else begin
      if (tx_last)       tx_words <= tx_words + 32'd1;
      if (host_out_fire) rx_words <= rx_words + 32'd1;
    end
  end
`endif

endmodule
